mux16_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the shared 16:1 mux datapath. Up to
//   16 requesters contend for the single mux output line; the block selects one

---
 rtl/mux16_rr_arbiter_if.sv | 31 +++
 rtl/mux16_rr_arbiter.sv | 98 +++++++++
 tb/tb_mux16_rr_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mux16_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the 16:1 round-robin mux arbiter.
// The master side is the arbiter; the slave side is the requester population.
interface mux16_rr_arbiter_if #(
    parameter int N    = 16,
    parameter int SELW = 4
);
    logic [N-1:0]    req;
    logic [N-1:0]    d;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic            y;

    modport master (
        input  req,
        input  d,
        output sel,
        output gnt,
        output gnt_valid,
        output y
    );

    modport slave (
        output req,
        output d,
        input  sel,
        input  gnt,
        input  gnt_valid,
        input  y
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Rotating-priority arbiter for a shared 16:1 mux: grants one requester for at most
// MAX_HOLD cycles, drives the select, and returns the selected data bit registered.
module mux16_rr_arbiter #(
    parameter int N        = 16,
    parameter int SELW     = 4,
    parameter int MAX_HOLD = 8,
    parameter int HCW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux16_rr_arbiter_if.master    bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            y_q, y_d;

    logic [N-1:0]    rot;
    logic [SELW-1:0] off;
    logic [SELW-1:0] winner;
    logic            release_now;

    // Requests rotated so that bit 0 is the requester at ptr; the index sum wraps mod 16.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = bus.req[SELW'(gi) + ptr_q];
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = SELW'(i);
        end
    end

    assign winner      = ptr_q + off;
    assign release_now = !bus.req[sel_q] || (hold_q == HCW'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        gnt_valid_d = gnt_valid_q;
        y_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    sel_d       = winner;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end
            end
            GRANT: begin
                y_d = bus.d[sel_q];
                if (release_now) begin
                    // sel is left on the last grantee; ptr moves just past it.
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            hold_q      <= '0;
            gnt_valid_q <= 1'b0;
            y_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            gnt_valid_q <= gnt_valid_d;
            y_q         <= y_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign bus.gnt[gi] = gnt_valid_q && (sel_q == SELW'(gi));
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.y         = y_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: hand-computed grant sequences, timeouts,
// pointer rotation, mid-grant reset and registered data return.
module tb_mux16_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    mux16_rr_arbiter_if bus_if ();

    mux16_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus_if.req = '0;
        bus_if.d   = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_gnt, d_pat;
        logic [3:0]  exp_sel, prev_sel;
        logic        exp_gv, prev_gv;
        logic [7:0]  tog;
        int          b, p;

        // 1: reset state, single requester, y one cycle behind grant
        do_reset();
        chk("rst_sel", 32'(bus_if.sel), 32'd0);
        chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("rst_gv",  32'(bus_if.gnt_valid), 32'd0);
        chk("rst_y",   32'(bus_if.y), 32'd0);
        bus_if.req = 16'h0001;
        bus_if.d   = 16'h0001;
        tick();
        chk("t1_gnt", 32'(bus_if.gnt), 32'h0001);
        chk("t1_sel", 32'(bus_if.sel), 32'd0);
        chk("t1_gv",  32'(bus_if.gnt_valid), 32'd1);
        chk("t1_y0",  32'(bus_if.y), 32'd0);
        tick();
        chk("t1_y1",  32'(bus_if.y), 32'd1);
        bus_if.req = '0;
        tick();
        chk("t1_rel_gv", 32'(bus_if.gnt_valid), 32'd0);
        chk("t1_rel_y",  32'(bus_if.y), 32'd1);
        tick();
        chk("t1_idle_y", 32'(bus_if.y), 32'd0);

        // 2: two requesters, timeout after 8, one dead cycle, wrap back to 3
        do_reset();
        bus_if.req = 16'h8008;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e <= 8)       exp_gnt = 16'h0008;
            else if (e == 9)  exp_gnt = 16'h0000;
            else if (e <= 17) exp_gnt = 16'h8000;
            else if (e == 18) exp_gnt = 16'h0000;
            else              exp_gnt = 16'h0008;
            exp_sel = (e >= 10 && e <= 18) ? 4'd15 : 4'd3;
            chk($sformatf("t2_gnt_e%0d", e), 32'(bus_if.gnt), 32'(exp_gnt));
            chk($sformatf("t2_sel_e%0d", e), 32'(bus_if.sel), 32'(exp_sel));
        end

        // 3: early drop on 5, ptr moves to 6, scan wraps to 0
        do_reset();
        bus_if.req = 16'h0020;
        tick();
        chk("t3_gnt5", 32'(bus_if.gnt), 32'h0020);
        tick();
        tick();
        bus_if.req = 16'h0001;
        tick();
        chk("t3_rel_gv",  32'(bus_if.gnt_valid), 32'd0);
        chk("t3_rel_gnt", 32'(bus_if.gnt), 32'd0);
        chk("t3_rel_sel", 32'(bus_if.sel), 32'd5);
        bus_if.req = 16'h0021;
        tick();
        chk("t3_next_gnt", 32'(bus_if.gnt), 32'h0001);
        chk("t3_next_sel", 32'(bus_if.sel), 32'd0);

        // 4: reset mid-grant
        do_reset();
        bus_if.req = 16'h0080;
        bus_if.d   = 16'h0080;
        tick();
        tick();
        chk("t4_gnt7", 32'(bus_if.gnt), 32'h0080);
        chk("t4_y7",   32'(bus_if.y), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_sel", 32'(bus_if.sel), 32'd0);
        chk("t4_rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("t4_rst_gv",  32'(bus_if.gnt_valid), 32'd0);
        chk("t4_rst_y",   32'(bus_if.y), 32'd0);
        bus_if.req = 16'h0081;
        tick();
        chk("t4_gnt0", 32'(bus_if.gnt), 32'h0001);

        // 5: all requesting, each index once in order, y follows d[sel] one cycle late
        do_reset();
        d_pat      = 16'hA5C3;
        bus_if.d   = d_pat;
        bus_if.req = 16'hFFFF;
        prev_gv    = 1'b0;
        prev_sel   = 4'd0;
        for (int e = 1; e <= 16 * 9; e++) begin
            tick();
            b       = (e - 1) / 9;
            p       = (e - 1) % 9;
            exp_gv  = (p < 8);
            exp_sel = 4'(b);
            exp_gnt = exp_gv ? (16'h0001 << b) : 16'h0000;
            chk($sformatf("t5_gnt_e%0d", e), 32'(bus_if.gnt), 32'(exp_gnt));
            chk($sformatf("t5_sel_e%0d", e), 32'(bus_if.sel), 32'(exp_sel));
            chk($sformatf("t5_y_e%0d", e), 32'(bus_if.y),
                32'(prev_gv ? d_pat[prev_sel] : 1'b0));
            prev_gv  = exp_gv;
            prev_sel = exp_sel;
        end

        // 6: toggling data on granted input is reproduced on y, then y=0 after release
        do_reset();
        tog        = 8'b1011_0010;
        bus_if.req = 16'h0004;
        tick();
        chk("t6_gnt2", 32'(bus_if.gnt), 32'h0004);
        for (int k = 0; k < 8; k++) begin
            bus_if.d = 16'(tog[k]) << 2;
            tick();
            chk($sformatf("t6_y_k%0d", k),  32'(bus_if.y), 32'(tog[k]));
            chk($sformatf("t6_gv_k%0d", k), 32'(bus_if.gnt_valid), 32'(k < 7));
        end
        bus_if.req = '0;
        tick();
        chk("t6_y_after", 32'(bus_if.y), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
